pwm_peripheral: RTL

//  Memory-mapped PWM timer downstream of the MMU/RAM data path; drives cpu port_pwm1.

---
 rtl/pwm_peripheral_pkg.sv | 24 ++
 rtl/pwm_peripheral_counter.sv | 61 ++++++
 rtl/pwm_peripheral.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pwm_peripheral_pkg.sv
// Shared definitions for the PWM peripheral: register map, CTRL bit positions,
// address-window geometry and the counter run state.
package pwm_peripheral_pkg;

    localparam int unsigned WIN_BYTES = 32;
    localparam int unsigned WIN_LSB   = $clog2(WIN_BYTES);

    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_PERIOD = 5'h04;
    localparam logic [4:0] OFF_DUTY   = 5'h08;
    localparam logic [4:0] OFF_COUNT  = 5'h0C;
    localparam logic [4:0] OFF_STATUS = 5'h10;

    localparam int unsigned CTRL_EN  = 0;
    localparam int unsigned CTRL_POL = 1;
    localparam int unsigned CTRL_UPD = 2;
    localparam int unsigned CTRL_IE  = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pwm_state_e;

endpackage

// File: rtl/pwm_peripheral_counter.sv
// Free-running PWM counter with shadow PERIOD/DUTY registers that reload from
// staging on every wrap and on restart.
module pwm_counter
    import pwm_peripheral_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_restart,
    input  logic [CNT_W-1:0] i_period,
    input  logic [CNT_W-1:0] i_duty,
    output logic [CNT_W-1:0] o_count,
    output logic             o_wrap,
    output logic             o_pwm_raw
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_period_a;
    logic [CNT_W-1:0] r_duty_a;
    pwm_state_e       w_state;
    logic             w_advance;
    logic             w_last;

    // i_en is the enable as it will be after this edge, so a disabling write idles at once
    always_comb begin
        w_state   = (i_en && (r_period_a != '0)) ? ST_RUN : ST_IDLE;
        w_advance = (w_state == ST_RUN) && !i_restart;
        w_last    = (r_count == (r_period_a - CNT_W'(1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_period_a <= '0;
            r_duty_a   <= '0;
        end else if (!i_en) begin
            r_count <= '0;
        end else if (i_restart) begin
            r_count    <= '0;
            r_period_a <= i_period;
            r_duty_a   <= i_duty;
        end else if (w_state == ST_RUN) begin
            if (w_last) begin
                r_count    <= '0;
                r_period_a <= i_period;
                r_duty_a   <= i_duty;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end else begin
            r_count <= '0;
        end
    end

    assign o_count   = r_count;
    assign o_wrap    = w_advance && w_last;
    assign o_pwm_raw = w_advance && (r_count < r_duty_a);

endmodule

// File: rtl/pwm_peripheral.sv
// Memory-mapped PWM timer: window decode, register file, readback and registered
// output. Define PWM_IRQ_EN to add the STATUS wrap flag, CTRL.IE and the irq port.
module pwm_peripheral
    import pwm_peripheral_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic        write_en,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        pwm_out
`ifdef PWM_IRQ_EN
    ,
    output logic        irq
`endif
);

    logic             r_en;
    logic             r_pol;
    logic [CNT_W-1:0] r_period_s;
    logic [CNT_W-1:0] r_duty_s;
    logic             r_pwm;

    logic             w_hit;
    logic [4:0]       w_off;
    logic             w_wr_ctrl;
    logic             w_wr_period;
    logic             w_wr_duty;
    logic             w_en_nxt;
    logic             w_pol_nxt;
    logic             w_restart;
    logic [CNT_W-1:0] w_count;
    logic             w_wrap;
    logic             w_pwm_raw;
    logic             w_unused;

    assign w_hit       = (address[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
    assign w_off       = address[WIN_LSB-1:0];
    assign w_wr_ctrl   = write_en && w_hit && (w_off == OFF_CTRL);
    assign w_wr_period = write_en && w_hit && (w_off == OFF_PERIOD);
    assign w_wr_duty   = write_en && w_hit && (w_off == OFF_DUTY);
    assign w_en_nxt    = w_wr_ctrl ? data_in[CTRL_EN]  : r_en;
    assign w_pol_nxt   = w_wr_ctrl ? data_in[CTRL_POL] : r_pol;
    // Restart on an enabling write from idle, or on UPD while enabled
    assign w_restart   = w_wr_ctrl && data_in[CTRL_EN] && (!r_en || data_in[CTRL_UPD]);

    pwm_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst),
        .i_en     (w_en_nxt),
        .i_restart(w_restart),
        .i_period (r_period_s),
        .i_duty   (r_duty_s),
        .o_count  (w_count),
        .o_wrap   (w_wrap),
        .o_pwm_raw(w_pwm_raw)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en       <= 1'b0;
            r_pol      <= 1'b0;
            r_period_s <= '0;
            r_duty_s   <= '0;
            r_pwm      <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_en  <= data_in[CTRL_EN];
                r_pol <= data_in[CTRL_POL];
            end
            if (w_wr_period) r_period_s <= data_in[CNT_W-1:0];
            if (w_wr_duty)   r_duty_s   <= data_in[CNT_W-1:0];
            r_pwm <= w_pwm_raw ^ w_pol_nxt;
        end
    end

    assign pwm_out = r_pwm;

`ifdef PWM_IRQ_EN
    logic r_ie;
    logic r_wrap_flag;
    logic r_irq;
    logic w_wr_status;

    assign w_wr_status = write_en && w_hit && (w_off == OFF_STATUS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ie        <= 1'b0;
            r_wrap_flag <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_ie <= data_in[CTRL_IE];
            if (w_wrap)
                r_wrap_flag <= 1'b1;
            else if (w_wr_status && data_in[0])
                r_wrap_flag <= 1'b0;
            r_irq <= r_wrap_flag & r_ie;
        end
    end

    assign irq      = r_irq;
    assign w_unused = ^data_in;
`else
    assign w_unused = ^{data_in, w_wrap};
`endif

    always_comb begin
        data_out = '0;
        if (w_hit) begin
            case (w_off)
                OFF_CTRL: begin
                    data_out[CTRL_EN]  = r_en;
                    data_out[CTRL_POL] = r_pol;
`ifdef PWM_IRQ_EN
                    data_out[CTRL_IE]  = r_ie;
`endif
                end
                OFF_PERIOD: data_out = 32'(r_period_s);
                OFF_DUTY:   data_out = 32'(r_duty_s);
                OFF_COUNT:  data_out = 32'(w_count);
`ifdef PWM_IRQ_EN
                OFF_STATUS: data_out[0] = r_wrap_flag;
`endif
                default: ;
            endcase
        end
    end

    assign data_ready = w_hit;

endmodule
